st2_id_ex_pipe: RTL
===================

# st2_id_ex_pipe

ID/EX pipeline boundary for the 16-bit pipelined datapath. It registers the decode-stage control word (from the stage-2 control unit) and its operands into the execute stage. It detects load-use hazards and inserts bubbles on them or on a branch flush. It also runs the halt-drain state machine that freezes fetch once a HALT (ctrlOp 4'b0000) enters execute.

## Interface
- DATA_W, 16, datapath/operand width
- REG_ADDR_W, 4, register address width
- DRAIN_CYCLES, 3, cycles after HALT capture before `halted` asserts (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_SE_Sel, id_regWrite, id_memRead, id_memWrite  in  2 each  control from decode
- id_ALUop, id_ctrlOp  in  4 each  control from decode
- id_R15Write, id_ALUsrc1, id_ALUsrc2, id_memToReg  in  1 each  control from decode
- id_rd1, id_rd2, id_imm, id_pc  in  DATA_W  register-file reads, sign-extended immediate, PC
- id_rs, id_rt, id_wr_addr  in  REG_ADDR_W  source and destination register numbers
- flush  in  1  branch taken in ID; squash the ID instruction
- ex_valid, ex_* (one per id_* above, same width)  out  registered copies
- stall  out  1  combinational; freezes PC and IF/ID when 1
- halted  out  1  registered; sticky until reset

## Operation
- load_use = ex_valid & (ex_memRead≠0) & (ex_regWrite≠0) & id_valid & (id_rs==ex_wr_addr | id_rt==ex_wr_addr). All 16 register numbers compare, R0 included.
- State machine: RUN, DRAIN, HALTED. 2-bit state and a down-counter wide enough for DRAIN_CYCLES.
- Per-edge priority: rst > state≠RUN > load_use > flush > capture.
- Capture: every ex_* register loads its id_* input; ex_valid ← id_valid.
- Bubble: all ex_* control and data fields ← 0; ex_valid ← 0.
- RUN:
  - load_use → bubble.
  - Otherwise flush → bubble.
  - Otherwise capture.
  - If the capture has id_valid=1 and id_ctrlOp=4'b0000 → DRAIN, cnt ← DRAIN_CYCLES.
- DRAIN: bubble every edge and cnt decrements. The edge on which cnt==1 moves to HALTED.
- HALTED: bubble every edge, halted=1. Only rst exits.
- stall = load_use | (state≠RUN). It is combinational from ID inputs, EX registers and state.
- flush is ignored in any cycle with stall=1. The ID instruction is held, and the upstream stage re-resolves the branch next cycle.
- The HALT instruction itself flows on as a valid entry with ctrlOp=0. Downstream stages treat it as a no-op.

## Timing
- Reset (async, immediate): all ex_* = 0, ex_valid=0, state=RUN, cnt=0, halted=0.
- Latency: ID→EX is one cycle.
- Load-use stall:
  - Lasts exactly one cycle per hazard, because the load moves past EX on the bubble edge.
  - stall rises in the same cycle the hazard is visible.
  - Output is glitch-tolerant: it is sampled only at clk.
- HALT:
  - HALT captured on edge N.
  - stall=1 from edge N onward.
  - halted=1 after edge N+DRAIN_CYCLES.
  - Bubbles enter EX on edges N+1 … N+DRAIN_CYCLES and onward.
- rst asserted mid-DRAIN clears state to RUN immediately; no partial drain persists.
- Simultaneous load_use and flush → single bubble, stall=1, flush dropped.
- HALT arriving in the same cycle as load_use or flush is not captured and causes no state change.

## Test plan
- Reset, then capture: id_valid=1, id_ALUop=4'h1, id_rd1=16'h1234, id_wr_addr=5 → after one edge ex_ALUop=1, ex_rd1=16'h1234, ex_wr_addr=5, ex_valid=1, stall=0.
- Load-use on rs:
  - Setup: EX holds lw (memRead=01, regWrite=01, wr_addr=3); ID has rs=3.
  - stall=1 in the same cycle.
  - Next edge: ex_valid=0 and all control fields 0.
  - Following cycle: stall=0 and the ID instruction is captured.
- Non-hazard: EX holds ADD writing R3 (memRead=0); ID reads R3 → stall=0, capture proceeds (forwarding case).
- Flush: flush=1 with id_valid=1, no hazard → ex_valid=0 after the edge. Repeat with load_use also active → stall=1, bubble, flush ignored.
- HALT with DRAIN_CYCLES=3:
  - id_ctrlOp=0, id_valid=1 captured at edge N.
  - stall=1 from N.
  - halted=1 after N+3.
  - ex_valid=0 on every edge after N.
  - id_valid inputs are ignored throughout.
- Reset mid-DRAIN: assert rst after edge N+1 → halted=0, stall=0, state=RUN immediately. A normal capture succeeds after rst deasserts.

Source files
------------

// File: rtl/st2_id_ex_pipe.sv
// ID/EX pipeline register for the 16-bit datapath: load-use bubble insertion,
// branch-flush squashing and the HALT drain sequence that freezes fetch.
module st2_id_ex_pipe #(
  parameter int DATA_W       = 16,
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [1:0]            id_SE_Sel,
  input  logic [1:0]            id_regWrite,
  input  logic [1:0]            id_memRead,
  input  logic [1:0]            id_memWrite,
  input  logic [3:0]            id_ALUop,
  input  logic [3:0]            id_ctrlOp,
  input  logic                  id_R15Write,
  input  logic                  id_ALUsrc1,
  input  logic                  id_ALUsrc2,
  input  logic                  id_memToReg,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [1:0]            ex_SE_Sel,
  output logic [1:0]            ex_regWrite,
  output logic [1:0]            ex_memRead,
  output logic [1:0]            ex_memWrite,
  output logic [3:0]            ex_ALUop,
  output logic [3:0]            ex_ctrlOp,
  output logic                  ex_R15Write,
  output logic                  ex_ALUsrc1,
  output logic                  ex_ALUsrc2,
  output logic                  ex_memToReg,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_wr_addr,
  output logic                  stall,
  output logic                  halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            SE_Sel;
    logic [1:0]            regWrite;
    logic [1:0]            memRead;
    logic [1:0]            memWrite;
    logic [3:0]            ALUop;
    logic [3:0]            ctrlOp;
    logic                  R15Write;
    logic                  ALUsrc1;
    logic                  ALUsrc2;
    logic                  memToReg;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] wr_addr;
  } ex_word_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       halted_q, halted_d;
  ex_word_t   ex_q, ex_d, id_word;
  logic       load_use;

  always_comb begin
    id_word.valid    = id_valid;
    id_word.SE_Sel   = id_SE_Sel;
    id_word.regWrite = id_regWrite;
    id_word.memRead  = id_memRead;
    id_word.memWrite = id_memWrite;
    id_word.ALUop    = id_ALUop;
    id_word.ctrlOp   = id_ctrlOp;
    id_word.R15Write = id_R15Write;
    id_word.ALUsrc1  = id_ALUsrc1;
    id_word.ALUsrc2  = id_ALUsrc2;
    id_word.memToReg = id_memToReg;
    id_word.rd1      = id_rd1;
    id_word.rd2      = id_rd2;
    id_word.imm      = id_imm;
    id_word.pc       = id_pc;
    id_word.rs       = id_rs;
    id_word.rt       = id_rt;
    id_word.wr_addr  = id_wr_addr;
  end

  // A load in EX whose destination matches either ID source (R0 included).
  assign load_use = ex_q.valid && (ex_q.memRead != 2'b00) && (ex_q.regWrite != 2'b00) &&
                    id_valid && ((id_rs == ex_q.wr_addr) || (id_rt == ex_q.wr_addr));

  assign stall = load_use || (state_q != RUN);

  always_comb begin
    ex_d     = '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    case (state_q)
      RUN: begin
        if (!load_use && !flush) begin
          ex_d = id_word;
          if (id_valid && (id_ctrlOp == 4'b0000)) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      ex_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      ex_q     <= ex_d;
    end
  end

  assign halted      = halted_q;
  assign ex_valid    = ex_q.valid;
  assign ex_SE_Sel   = ex_q.SE_Sel;
  assign ex_regWrite = ex_q.regWrite;
  assign ex_memRead  = ex_q.memRead;
  assign ex_memWrite = ex_q.memWrite;
  assign ex_ALUop    = ex_q.ALUop;
  assign ex_ctrlOp   = ex_q.ctrlOp;
  assign ex_R15Write = ex_q.R15Write;
  assign ex_ALUsrc1  = ex_q.ALUsrc1;
  assign ex_ALUsrc2  = ex_q.ALUsrc2;
  assign ex_memToReg = ex_q.memToReg;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_wr_addr  = ex_q.wr_addr;

endmodule
